// File: rtl/regfile16_clearable.sv
// regfile16_clearable: 16-entry x N-bit register file with one synchronous
// write port, two combinational read ports and a sequenced clear engine.
// The clear engine wipes the bank one entry per cycle. It lets software
// clear all state without using the full reset.

// mux16: selects one of sixteen N-bit inputs. Each read port uses one.
module mux16 #(
  parameter int N = 32
) (
  input  logic [15:0][N-1:0] data,
  input  logic [3:0]         sel,
  output logic [N-1:0]       out
);

  // Plain 16:1 selection of the register outputs.
  always_comb begin
    out = '0;
    case (sel)
      4'd0:    out = data[0];
      4'd1:    out = data[1];
      4'd2:    out = data[2];
      4'd3:    out = data[3];
      4'd4:    out = data[4];
      4'd5:    out = data[5];
      4'd6:    out = data[6];
      4'd7:    out = data[7];
      4'd8:    out = data[8];
      4'd9:    out = data[9];
      4'd10:   out = data[10];
      4'd11:   out = data[11];
      4'd12:   out = data[12];
      4'd13:   out = data[13];
      4'd14:   out = data[14];
      4'd15:   out = data[15];
      default: out = '0;
    endcase
  end

endmodule

module regfile16_clearable #(
  parameter int N        = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [3:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [3:0]   rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [3:0]   rd_addr1,
  output logic [N-1:0] rd_data1,
  input  logic         clear_req,
  output logic         busy
);

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;
  logic [3:0] counter_q;
  logic [3:0] counter_d;

  logic [15:0][N-1:0] bank;
  logic [N-1:0] mux_out0;
  logic [N-1:0] mux_out1;

  logic clear_en;
  logic wr_accept;
  logic zero_reg_on;
  logic bypass_on;

  assign zero_reg_on = (ZERO_REG != 0);
  assign bypass_on   = (BYPASS != 0);

  // A write is dropped while clearing, and also when it targets the hardwired zero entry.
  assign clear_en  = (state_q == CLEARING);
  assign wr_accept = wr_ena && (state_q == IDLE) && !(zero_reg_on && (wr_addr == 4'd0));

  assign busy = (state_q == CLEARING);

  // State register and clear counter. Reset has priority over everything, including a clear in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Next-state logic. A clear always runs all 16 entries. A clear_req seen while clearing has no effect.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEARING;
          counter_d = 4'd0;
        end
      end
      CLEARING: begin
        counter_d = counter_q + 4'd1;
        if (counter_q == 4'd15) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = 4'd0;
      end
    endcase
  end

  // Register bank. The clear engine and the write port never act in the same cycle, because writes need IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      bank <= '0;
    end else if (clear_en) begin
      bank[counter_q] <= '0;
    end else if (wr_accept) begin
      bank[wr_addr] <= wr_data;
    end
  end

  mux16 #(.N(N)) u_mux0 (
    .data (bank),
    .sel  (rd_addr0),
    .out  (mux_out0)
  );

  mux16 #(.N(N)) u_mux1 (
    .data (bank),
    .sel  (rd_addr1),
    .out  (mux_out1)
  );

  // Read port 0 priority: hardwired zero, then write-through, then stored value.
  always_comb begin
    rd_data0 = mux_out0;
    if (zero_reg_on && (rd_addr0 == 4'd0)) begin
      rd_data0 = '0;
    end else if (bypass_on && wr_accept && (wr_addr == rd_addr0)) begin
      rd_data0 = wr_data;
    end
  end

  // Read port 1 uses the same priority as port 0 and is independent of it.
  always_comb begin
    rd_data1 = mux_out1;
    if (zero_reg_on && (rd_addr1 == 4'd0)) begin
      rd_data1 = '0;
    end else if (bypass_on && wr_accept && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end
  end

endmodule

// File: tb/tb_regfile16_clearable.sv
// tb_regfile16_clearable: checks regfile16_clearable against an array-based
// reference model. Two instances (BYPASS=1 and BYPASS=0) share all inputs.
module tb_regfile16_clearable;

  logic        clk;
  logic        rst;
  logic        wr_ena;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr0;
  logic [3:0]  rd_addr1;
  logic        clear_req;
  logic [31:0] rd_data0;
  logic [31:0] rd_data1;
  logic        busy;
  logic [31:0] nb_rd_data0;
  logic [31:0] nb_rd_data1;
  logic        nb_busy;

  int checkCount;
  int errorCount;

  // The model stores the bank as an array. The clear engine is a count of the
  // entries still to wipe plus the index of the next entry.
  logic [31:0] mem [16];
  int clrLeft;
  int clrIdx;

  regfile16_clearable #(.N(32), .ZERO_REG(1), .BYPASS(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr0  (rd_addr0),
    .rd_data0  (rd_data0),
    .rd_addr1  (rd_addr1),
    .rd_data1  (rd_data1),
    .clear_req (clear_req),
    .busy      (busy)
  );

  regfile16_clearable #(.N(32), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .clk       (clk),
    .rst       (rst),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr0  (rd_addr0),
    .rd_data0  (nb_rd_data0),
    .rd_addr1  (rd_addr1),
    .rd_data1  (nb_rd_data1),
    .clear_req (clear_req),
    .busy      (nb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Expected read value, derived from the read rules rather than from the RTL structure.
  function automatic logic [31:0] expRead(input logic [3:0] a, input bit byp);
    if (a == 4'd0) return 32'd0;
    if (byp && wr_ena && (clrLeft == 0) && (wr_addr == a)) return wr_data;
    return mem[a];
  endfunction

  // Advances the model by one rising edge, using the inputs currently driven.
  task automatic modelStep();
    if (rst) begin
      foreach (mem[i]) mem[i] = 32'd0;
      clrLeft = 0;
      clrIdx  = 0;
    end else if (clrLeft > 0) begin
      mem[clrIdx] = 32'd0;
      clrIdx  = (clrIdx + 1) % 16;
      clrLeft = clrLeft - 1;
    end else begin
      if (wr_ena && (wr_addr != 4'd0)) mem[wr_addr] = wr_data;
      if (clear_req) begin
        clrLeft = 16;
        clrIdx  = 0;
      end
    end
  endtask

  // Drives one cycle of inputs, checks all outputs before the edge, then advances the model.
  task automatic applyStimulus(input bit r, input bit we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] a0, input logic [3:0] a1, input bit cr);
    rst = r; wr_ena = we; wr_addr = wa; wr_data = wd;
    rd_addr0 = a0; rd_addr1 = a1; clear_req = cr;
    #1;
    checkOutput("rd_data0", rd_data0, expRead(a0, 1'b1));
    checkOutput("rd_data1", rd_data1, expRead(a1, 1'b1));
    checkOutput("nb_rd_data0", nb_rd_data0, expRead(a0, 1'b0));
    checkOutput("nb_rd_data1", nb_rd_data1, expRead(a1, 1'b0));
    checkOutput("busy", {31'd0, busy}, {31'd0, clrLeft > 0});
    checkOutput("nb_busy", {31'd0, nb_busy}, {31'd0, clrLeft > 0});
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic idleCycle(input logic [3:0] a0, input logic [3:0] a1);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, a0, a1, 1'b0);
  endtask

  // Counts busy cycles, up to a bound, and checks that a clear lasts exactly 16 cycles.
  task automatic measureBusy(input string tag);
    int n;
    n = 0;
    while (busy && n < 40) begin
      idleCycle(4'(n), 4'(15 - n));
      n++;
    end
    checkOutput(tag, 32'(n), 32'd16);
  endtask

  task automatic checkAllZero(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr0 = 4'(a); rd_addr1 = 4'(15 - a); wr_ena = 1'b0; clear_req = 1'b0; rst = 1'b0;
      #1;
      checkOutput(tag, rd_data0, 32'd0);
      checkOutput(tag, rd_data1, 32'd0);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    foreach (mem[i]) mem[i] = 32'hxxxx_xxxx;
    clrLeft = 0;
    clrIdx  = 0;
    rst = 1'b1; wr_ena = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;
    rd_addr0 = 4'd0; rd_addr1 = 4'd0; clear_req = 1'b0;

    @(negedge clk);
    @(posedge clk);
    modelStep();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] reset state");
    for (int a = 0; a < 16; a++) idleCycle(4'(a), 4'(15 - a));
    checkAllZero("reset_zero");
    #1 checkOutput("reset_busy", {31'd0, busy}, 32'd0);

    $display("[TB] basic writes");
    applyStimulus(1'b0, 1'b1, 4'd5, 32'hDEADBEEF, 4'd1, 4'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd15, 32'h12345678, 4'd5, 4'd1, 1'b0);
    rd_addr0 = 4'd5; rd_addr1 = 4'd15; wr_ena = 1'b0;
    #1;
    checkOutput("wr_addr5", rd_data0, 32'hDEADBEEF);
    checkOutput("wr_addr15", rd_data1, 32'h12345678);
    idleCycle(4'd5, 4'd15);

    $display("[TB] zero register");
    applyStimulus(1'b0, 1'b1, 4'd0, 32'hFFFFFFFF, 4'd0, 4'd0, 1'b0);
    rd_addr0 = 4'd0; wr_ena = 1'b0;
    #1 checkOutput("zero_reg", rd_data0, 32'd0);
    idleCycle(4'd0, 4'd5);

    $display("[TB] bypass");
    applyStimulus(1'b0, 1'b1, 4'd3, 32'h00000033, 4'd4, 4'd4, 1'b0);
    wr_ena = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5A5A5; rd_addr0 = 4'd3; rd_addr1 = 4'd3;
    #1;
    checkOutput("bypass_on", rd_data0, 32'hA5A5A5A5);
    checkOutput("bypass_off", nb_rd_data0, 32'h00000033);
    applyStimulus(1'b0, 1'b1, 4'd3, 32'hA5A5A5A5, 4'd3, 4'd3, 1'b0);
    idleCycle(4'd3, 4'd3);

    $display("[TB] clear sequence");
    for (int a = 1; a < 16; a++) applyStimulus(1'b0, 1'b1, 4'(a), 32'(a), 4'(a), 4'(a - 1), 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 4'd8, 4'd12, 1'b1);
    begin
      int n;
      n = 0;
      while (busy && n < 40) begin
        if (n == 8) begin
          rd_addr0 = 4'd7; rd_addr1 = 4'd8; wr_ena = 1'b0; clear_req = 1'b0;
          #1;
          checkOutput("mid_addr7", rd_data0, 32'd0);
          checkOutput("mid_addr8", rd_data1, 32'd8);
        end
        if (n == 4) applyStimulus(1'b0, 1'b1, 4'd12, 32'h55, 4'd12, 4'd12, 1'b0);
        else if (n == 6) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 4'd12, 4'(n), 1'b1);
        else idleCycle(4'(n), 4'd12);
        n++;
      end
      checkOutput("clear_busy_len", 32'(n), 32'd16);
    end
    checkAllZero("after_clear");

    $display("[TB] reset mid-clear");
    for (int a = 1; a < 16; a++) applyStimulus(1'b0, 1'b1, 4'(a), 32'(a * 3 + 1), 4'(a), 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 4'd1, 4'd2, 1'b1);
    for (int k = 0; k < 3; k++) idleCycle(4'(k), 4'(k + 4));
    applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 4'd9, 4'd10, 1'b0);
    #1 checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkAllZero("rst_mid_zero");
    applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0, 1'b1);
    measureBusy("rst_then_clear_len");

    $display("[TB] random phase");
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                    4'($urandom_range(0, 15)), $urandom(),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 39) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Overall time limit, so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/regfile16_clearable.md
Name: regfile16_clearable

Overview:
- 16-entry x N-bit register file with one synchronous write port and two combinational read ports.
- Each read port is built from a mux16 instance over the 16 register outputs.
- Sits directly upstream of the read-select muxing: the register bank that the mux16 consumes.
- Adds a sequenced clear engine that zeroes the bank one entry per cycle, so software can wipe state without a full reset.

Parameters:
- N, 32, data width of every register and data port.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1, a read of the address being written in the same cycle returns wr_data (write-through).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_ena  input  1  write request for this cycle.
- wr_addr  input  4  write address.
- wr_data  input  N  write data.
- rd_addr0  input  4  read port 0 address.
- rd_data0  output  N  read port 0 data (combinational).
- rd_addr1  input  4  read port 1 address.
- rd_data1  output  N  read port 1 data (combinational).
- clear_req  input  1  single-cycle pulse requesting a sequenced clear.
- busy  output  1  high while the clear engine is running.

Behaviour:
- Reset is synchronous and active-high: when rst is high at a rising edge of clk, all 16 registers become 0, the FSM goes to IDLE, the clear counter becomes 0 and busy becomes 0. Reset wins over every other input, including mid-clear.
- FSM states: IDLE and CLEARING. busy = (state == CLEARING), driven from registered state only.
- IDLE, clear_req=1: go to CLEARING next cycle with counter=0.
- IDLE, clear_req=0: stay in IDLE.
- CLEARING, each cycle: reg[counter] <= 0, then counter <= counter+1.
- CLEARING, counter==15: clear entry 15 and go to IDLE next cycle. busy is high for exactly 16 cycles. counter wraps to 0.
- clear_req while in CLEARING is ignored; it does not restart or extend the clear.
- Write accepted = wr_ena && state==IDLE && !(ZERO_REG && wr_addr==0). When accepted, reg[wr_addr] <= wr_data at the rising edge.
- Writes requested during CLEARING are dropped silently. There is no stall or backpressure; the upstream block must gate on busy.
- wr_ena and clear_req in the same IDLE cycle: the write is performed that edge, then CLEARING starts and later zeroes it. Net result: the whole bank is 0 when busy falls.
- Read latency is zero (combinational); data path is rd_dataX = mux16(reg[0..15], rd_addrX).
- Read priority for rd_dataX:
  - if ZERO_REG && rd_addrX==0, output 0;
  - else if BYPASS && write accepted && wr_addr==rd_addrX, output wr_data;
  - else output reg[rd_addrX].
- During CLEARING, reads return current contents: already-cleared entries read 0, the rest keep their old values. No bypass applies, because no write is accepted.
- Both read ports are fully independent and may target the same address.
- All widths are exactly N; no sign extension or truncation inside the block.

Test Plan:
- Reset, then read all 16 addresses on both ports -> every read is 0 and busy=0.
- Write 0xDEADBEEF to addr 5, then 0x12345678 to addr 15. Read both ports next cycle -> rd_data0 at addr 5 is 0xDEADBEEF, rd_data1 at addr 15 is 0x12345678.
- ZERO_REG: write 0xFFFFFFFF to addr 0 -> read addr 0 gives 0.
- Bypass: wr_ena=1, wr_addr=3, wr_data=0xA5A5A5A5 with rd_addr0=3 in the same cycle -> rd_data0=0xA5A5A5A5 before the edge. With BYPASS=0 -> the old value of reg 3.
- Clear sequence:
  - Setup: fill addrs 1..15 with value=addr, then pulse clear_req.
  - busy is high for exactly 16 cycles.
  - Mid-sequence: after 8 busy cycles, addrs 0..7 read 0 and addr 8 still reads 8.
  - A write of 0x55 to addr 12 while busy is dropped.
  - A second clear_req while busy has no effect.
  - After busy falls, all entries read 0.
- Reset mid-clear: assert rst on the 4th busy cycle -> next cycle busy=0 and all entries read 0. A following clear_req gives a full 16-cycle busy again.
